// File: rtl/regfile_dump_reader_if.sv
// Register-file read port plus {addr, data} valid/ready output stream of the dump reader.
interface regfile_dump_reader_if #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 16
);
   logic [ADDR_W-1:0] rf_addr;
   logic [DATA_W-1:0] rf_data;
   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] out_addr;
   logic [DATA_W-1:0] out_data;
   logic              out_last;

   modport master (
      output rf_addr,
      input  rf_data,
      output out_valid,
      output out_addr,
      output out_data,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  rf_addr,
      output rf_data,
      input  out_valid,
      input  out_addr,
      input  out_data,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks a register-file read port from 0 to NUM_REGS-1 on start and streams each
// register as an {address, data} word; never writes the register file.
module regfile_dump_reader #(
   parameter int unsigned NUM_REGS = 16,
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned DATA_W   = 16
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   start_i,
   output logic                   busy_o,
   output logic                   done_o,
   regfile_dump_reader_if.master  dump_io
);

   localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_REGS - 1);

   typedef enum logic [1:0] {StIdle, StRead, StSend, StDone} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic                out_last_q, out_last_d;
   logic                out_valid_q, out_valid_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= StIdle;
         idx_q       <= '0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         out_addr_q  <= out_addr_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         StIdle: begin
            idx_d = '0;
            if (start_i) state_d = StRead;
         end
         StRead: state_d = StSend;
         StSend: begin
            if (dump_io.out_ready) begin
               if (out_last_q) begin
                  state_d = StDone;
               end else begin
                  idx_d   = idx_q + ADDR_W'(1);
                  state_d = StRead;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Status flags are registered from the next state so they line up with it.
   always_comb begin
      out_addr_d = out_addr_q;
      out_data_d = out_data_q;
      out_last_d = out_last_q;
      if (state_q == StRead) begin
         out_addr_d = idx_q;
         out_data_d = dump_io.rf_data;
         out_last_d = (idx_q == LastIdx);
      end
      out_valid_d = (state_d == StSend);
      busy_d      = (state_d != StIdle);
      done_d      = (state_d == StDone);
   end

   assign dump_io.rf_addr   = idx_q;
   assign dump_io.out_valid = out_valid_q;
   assign dump_io.out_addr  = out_addr_q;
   assign dump_io.out_data  = out_data_q;
   assign dump_io.out_last  = out_last_q;
   assign busy_o            = busy_q;
   assign done_o            = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: stimulus queues expected words, monitors check them.
module tb_regfile_dump_reader;

   typedef struct packed {
      logic [3:0]  a;
      logic [15:0] d;
      logic        l;
   } word_t;

   logic CLK = 1'b0;
   logic RESET = 1'b1;
   logic start = 1'b0;
   logic start4 = 1'b0;
   logic busy, done, busy4, done4;

   always #5 CLK = ~CLK;

   regfile_dump_reader_if #(.ADDR_W(4), .DATA_W(16)) bus ();
   regfile_dump_reader_if #(.ADDR_W(4), .DATA_W(16)) bus4 ();

   logic [15:0] rf [16];
   assign bus.rf_data  = rf[bus.rf_addr];
   assign bus4.rf_data = rf[bus4.rf_addr];

   regfile_dump_reader #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(16)) u_dut (
      .CLK     (CLK),
      .RESET   (RESET),
      .start_i (start),
      .busy_o  (busy),
      .done_o  (done),
      .dump_io (bus)
   );

   regfile_dump_reader #(.NUM_REGS(4), .ADDR_W(4), .DATA_W(16)) u_dut4 (
      .CLK     (CLK),
      .RESET   (RESET),
      .start_i (start4),
      .busy_o  (busy4),
      .done_o  (done4),
      .dump_io (bus4)
   );

   int n_vec = 0;
   int n_err = 0;
   int done_cnt = 0;
   int done4_cnt = 0;
   int cyc = 0;
   int first_read = 0;
   int last_accept = 0;
   word_t exp_q [$];
   word_t exp4_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Main monitor: handshakes, stall stability and done timing.
   logic        prev_stall = 1'b0;
   logic        prev_busy = 1'b0;
   logic        expect_done = 1'b0;
   logic [3:0]  prev_addr = '0;
   logic [15:0] prev_data = '0;
   always @(negedge CLK) begin
      word_t w;
      cyc++;
      if (RESET) begin
         prev_stall  = 1'b0;
         prev_busy   = 1'b0;
         expect_done = 1'b0;
      end else begin
         if (busy && !prev_busy) first_read = cyc;
         prev_busy = busy;
         if (expect_done) begin
            check("done_after_last", 32'(done), 32'd1);
            expect_done = 1'b0;
         end else if (done) begin
            check("done_unexpected", 32'(done), 32'd0);
         end
         if (done) done_cnt++;
         if (prev_stall) begin
            check("stall_addr", 32'(bus.out_addr), 32'(prev_addr));
            check("stall_data", 32'(bus.out_data), 32'(prev_data));
            check("stall_valid", 32'(bus.out_valid), 32'd1);
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL extra_word: got addr %0d, want no word", bus.out_addr);
            end else begin
               w = exp_q.pop_front();
               check("word_addr", 32'(bus.out_addr), 32'(w.a));
               check("word_data", 32'(bus.out_data), 32'(w.d));
               check("word_last", 32'(bus.out_last), 32'(w.l));
               if (w.l) begin
                  expect_done = 1'b1;
                  last_accept = cyc;
               end
            end
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_addr  = bus.out_addr;
         prev_data  = bus.out_data;
      end
   end

   // Monitor for the NUM_REGS=4 instance.
   logic expect_done4 = 1'b0;
   always @(negedge CLK) begin
      word_t w;
      if (RESET) begin
         expect_done4 = 1'b0;
      end else begin
         if (expect_done4) begin
            check("done4_after_last", 32'(done4), 32'd1);
            expect_done4 = 1'b0;
         end
         if (done4) done4_cnt++;
         if (bus4.out_valid && bus4.out_ready) begin
            if (exp4_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL extra_word4: got addr %0d, want no word", bus4.out_addr);
            end else begin
               w = exp4_q.pop_front();
               check("word4_addr", 32'(bus4.out_addr), 32'(w.a));
               check("word4_data", 32'(bus4.out_data), 32'(w.d));
               check("word4_last", 32'(bus4.out_last), 32'(w.l));
               if (w.l) expect_done4 = 1'b1;
            end
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic push_dump(input int n_words, input logic [15:0] d12);
      word_t w;
      for (int i = 0; i < n_words; i++) begin
         w.a = 4'(i);
         w.d = (i == 12) ? d12 : 16'h1000 + 16'(i);
         w.l = (i == 15);
         exp_q.push_back(w);
      end
   endtask

   task automatic pulse_start();
      step();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // mode 0: ready held; 1: 5-cycle stalls + random; 2: stray starts; 3: rewrite during stall
   task automatic run_dump(input int target, input int mode, input int budget);
      int hold = 0;
      for (int k = 0; k < budget; k++) begin
         step();
         start = 1'b0;
         if (done_cnt >= target) break;
         case (mode)
            1: bus.out_ready = (k % 9 < 5) ? 1'b0 : 1'($urandom_range(0, 1));
            2: begin
               bus.out_ready = 1'b1;
               start = (bus.out_valid && bus.out_addr == 4'd7) || done;
            end
            3: begin
               bus.out_ready = 1'b1;
               if (bus.out_valid && bus.out_addr == 4'd3 && hold < 5) begin
                  bus.out_ready = 1'b0;
                  hold++;
                  if (hold == 2) begin
                     rf[12] = 16'hBEEF;
                     rf[2]  = 16'hDEAD;
                  end
               end
            end
            default: bus.out_ready = 1'b1;
         endcase
      end
      bus.out_ready = 1'b1;
      check("done_count", 32'(done_cnt), 32'(target));
      repeat (4) step();
      check("single_done", 32'(done_cnt), 32'(target));
      check("busy_after", 32'(busy), 32'd0);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) rf[i] = 16'h1000 + 16'(i);
      bus.out_ready  = 1'b1;
      bus4.out_ready = 1'b1;

      // Reset values
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_addr", 32'(bus.out_addr), 32'd0);
      check("rst_data", 32'(bus.out_data), 32'd0);
      check("rst_last", 32'(bus.out_last), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_rf_addr", 32'(bus.rf_addr), 32'd0);
      check("rst_busy4", 32'(busy4), 32'd0);
      RESET = 1'b0;

      // Full dump, ready held, latency and length
      push_dump(16, 16'h100C);
      pulse_start();
      @(negedge CLK);
      check("lat_busy", 32'(busy), 32'd1);
      check("lat_valid_early", 32'(bus.out_valid), 32'd0);
      check("lat_rf_addr", 32'(bus.rf_addr), 32'd0);
      @(negedge CLK);
      check("lat_valid", 32'(bus.out_valid), 32'd1);
      check("lat_addr", 32'(bus.out_addr), 32'd0);
      check("lat_data", 32'(bus.out_data), 32'h1000);
      run_dump(1, 0, 200);
      check("dump_cycles", 32'(last_accept - first_read + 1), 32'd32);

      // Backpressure with 5-cycle stalls
      push_dump(16, 16'h100C);
      pulse_start();
      run_dump(2, 1, 800);

      // Start pulses at word 7 and during DONE are ignored
      push_dump(16, 16'h100C);
      pulse_start();
      run_dump(3, 2, 200);

      // Reset while word 9 is stalled
      push_dump(9, 16'h100C);
      pulse_start();
      for (int k = 0; k < 200; k++) begin
         step();
         bus.out_ready = 1'b1;
         if (bus.out_valid && bus.out_addr == 4'd9) begin
            bus.out_ready = 1'b0;
            break;
         end
      end
      step();
      step();
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      @(negedge CLK);
      check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      check("mid_rst_addr", 32'(bus.out_addr), 32'd0);
      check("mid_rst_data", 32'(bus.out_data), 32'd0);
      check("mid_rst_last", 32'(bus.out_last), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_rf_addr", 32'(bus.rf_addr), 32'd0);
      check("mid_rst_queue", 32'(exp_q.size()), 32'd0);
      bus.out_ready = 1'b1;
      push_dump(16, 16'h100C);
      pulse_start();
      run_dump(4, 0, 200);

      // Rewrites during the reg-3 stall: reg 12 visible, reg 2 already sent
      push_dump(16, 16'hBEEF);
      pulse_start();
      run_dump(5, 3, 300);
      rf[12] = 16'h100C;
      rf[2]  = 16'h1002;

      // NUM_REGS=4 instance
      for (int i = 0; i < 4; i++) begin
         word_t w;
         w.a = 4'(i);
         w.d = 16'h1000 + 16'(i);
         w.l = (i == 3);
         exp4_q.push_back(w);
      end
      step();
      start4 = 1'b1;
      step();
      start4 = 1'b0;
      for (int k = 0; k < 100; k++) begin
         step();
         if (done4_cnt >= 1) break;
      end
      check("done4_count", 32'(done4_cnt), 32'd1);
      repeat (3) step();
      check("single_done4", 32'(done4_cnt), 32'd1);
      check("busy4_after", 32'(busy4), 32'd0);
      check("queue4_empty", 32'(exp4_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

- Read-side companion to the CPU register file.
- On a `start` pulse, walks the register file's read port from register 0 to `NUM_REGS-1`.
- Each register value is captured and presented as one {address, data} word on a valid/ready stream toward the debug/display path.
- Nothing is ever written into the register file. The block only drives a read address and samples the returned data.

## Interface
Parameters:
- `NUM_REGS`, 16, number of registers dumped (addresses 0..NUM_REGS-1)
- `ADDR_W`, 4, register address width
- `DATA_W`, 16, register data width

Ports:
- `CLK`  in  1  single clock; all state updates on rising edge
- `RESET`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request to begin a dump; ignored while `busy`=1
- `rf_addr`  out  ADDR_W  read address to a register-file read port
- `rf_data`  in  DATA_W  combinational read data for `rf_addr`, valid in the same cycle
- `out_valid`  out  1  output word available
- `out_ready`  in  1  downstream accepts the word
- `out_addr`  out  ADDR_W  register index of the current word
- `out_data`  out  DATA_W  register value of the current word
- `out_last`  out  1  current word is register NUM_REGS-1
- `busy`  out  1  dump in progress (states other than IDLE)
- `done`  out  1  one-cycle pulse after the final word is accepted

## Operation
- FSM states: IDLE, READ, SEND, DONE.
- **IDLE**
  - `start`=1 → READ.
  - Index counter `idx` loads 0.
- **READ**
  - `rf_addr`=`idx`.
  - At the rising edge, `rf_data` is captured into the `out_data` register and `idx` into `out_addr`.
  - `out_last` is set to (`idx`==NUM_REGS-1).
  - Next state: SEND.
- **SEND**
  - `out_valid`=1.
  - On `out_valid` & `out_ready` at an edge:
    - If `out_last`: → DONE.
    - Otherwise: `idx` increments by 1, → READ.
  - While `out_ready`=0: `out_addr`, `out_data`, `out_last` and `out_valid` stay unchanged.
- **DONE**
  - `done`=1 for exactly this one cycle.
  - → IDLE unconditionally.
  - A `start` seen in DONE is ignored.
- `rf_addr` outside READ holds `idx` (don't-care for the register file, but stable).
- `idx` is ADDR_W wide; it never increments past NUM_REGS-1, so there is no wrap-around.
- Each value reflects the register contents in that register's READ cycle. There is no global snapshot: a write landing between READ cycles is visible only for registers not yet read.
- `start` while `busy`=1: no effect, no restart, no queueing.
- `RESET`=1 at any edge, including mid-dump:
  - FSM → IDLE, `idx`=0.
  - `out_valid`=0, `out_addr`=0, `out_data`=0, `out_last`=0, `busy`=0, `done`=0, `rf_addr`=0.
  - An in-flight word is dropped without a handshake.

## Timing
- Reset values: all outputs 0.
- `start` sampled at edge E0 → READ during cycle after E0, `busy`=1 from that cycle.
- First word: `out_valid`=1 in the cycle after E0+1, i.e. 2 cycles after `start`.
- Per word with `out_ready` held 1: 2 cycles (READ + SEND). A full 16-register dump is 32 cycles from the first READ to the last accept.
- `done` asserts the cycle after the last handshake; `busy` stays 1 through DONE and drops the cycle after.
- Back-to-back dumps: a `start` in the cycle after DONE (IDLE) is accepted.
- Outputs `out_*`, `busy`, `done` are registered. `rf_addr` is registered (from `idx`).

## Test plan
- Registers preloaded with value 0x1000+i (i=0..15), `out_ready`=1, pulse `start` → 16 words, addr 0..15 in order, data 0x1000..0x100F; `out_last` only on addr 15; `done` pulses once 1 cycle after the last accept; 32 cycles from first READ to last accept.
- Same preload, `out_ready` toggled pseudo-randomly, including 5-cycle stalls → same 16 words in order; `out_addr`/`out_data` are constant during every stall; no duplicates or drops.
- `start` pulsed again at word 7 and during DONE → ignored; exactly 16 words and a single `done`.
- `RESET`=1 while word 9 is pending with `out_ready`=0 → next cycle all outputs 0 and FSM in IDLE. A new `start` then begins again at addr 0.
- Register 12 rewritten to 0xBEEF while the word for reg 3 is stalled → the dump reports 0xBEEF for reg 12. Rewriting reg 2 at the same point does not change its already-sent value.
- `NUM_REGS`=4 parameter override → words for addr 0..3 only; `out_last` on addr 3.
